mux8_rr_sched: RTL and testbench
================================

Name: mux8_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux output among eight requesters.
- Each requester raises req[i] and drives its data bit on din[i]. The block grants one requester at a time, drives the mux select, and routes the granted bit to out.
- Grants are held for at most MAX_HOLD cycles so no requester can starve the others.
- Sits in front of any shared single-bit resource (serial line, LED, test pin) that previously used a fixed select.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant may last. Legal range 1..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  8  request vector; req[i]=1 means requester i wants the resource.
- din  input  8  data bits; din[i] belongs to requester i.
- gnt  output 8  registered one-hot grant, or all-zero when idle.
- sel  output 3  registered select index of the current grantee.
- busy output 1  registered; 1 while a grant is active.
- out  output 1  combinational: din[sel] when busy=1, else 0.

Behaviour:
- Reset (rst=1 at an edge, takes priority over everything): gnt=0, sel=0, busy=0, hold counter=0, last-served pointer=7, state=IDLE. As a result, out=0 and the first priority goes to req[0]. Reset asserted mid-grant drops the grant at that edge, with no completion of the hold.
- States are IDLE and GRANT; busy=1 exactly in GRANT.
- Winner selection is combinational: scan indices (last+1) mod 8, (last+2) mod 8, … through last. The first index with req=1 wins. The scan wraps from 7 to 0.
- IDLE:
  - If req=0, stay in IDLE.
  - Otherwise, at the edge: go to GRANT, set sel=winner, gnt=1<<winner, counter=0.
  - Grant latency is one cycle: a request seen at edge t is granted and visible after edge t.
- GRANT, at each edge, a release occurs if req[sel]=0 or counter==MAX_HOLD-1. On release:
  - Set last=sel.
  - Recompute the winner from the current req, starting at the new last+1.
  - If any req is set: grant the winner back-to-back with no idle cycle, and set counter=0.
  - If no req is set: go to IDLE with gnt=0 and busy=0; sel keeps its value.
- GRANT, no release: counter increments and gnt and sel hold.
- A requester that is released by expiry may be re-granted immediately only if no other req bit is set.
- A grant therefore lasts between 1 and MAX_HOLD cycles. With MAX_HOLD=1, grants rotate every cycle among the active requesters.
- Simultaneous events:
  - The grantee dropping its req and another requester rising in the same cycle is a normal release plus re-arbitration.
  - req changes during a grant do not affect the current grant except req[sel].
- gnt is always one-hot or zero, and consistent with sel and busy.
- out follows din[sel] combinationally, so din changes pass through in the same cycle.

Decomposition:
- Shared package/header holds:
  - NREQ=8 and SEL_W=3 constants.
  - State encodings ST_IDLE=1'b0 and ST_GRANT=1'b1.
- One sub-module, rr_pick8: purely combinational. Inputs are req[7:0] and last[2:0]; outputs are any and win[2:0]. It implements the rotating priority scan.
- Everything else stays in mux8_rr_sched: FSM, counter, registers, and the output mux expression.

Test Plan:
- Reset, then req=8'b0000_0001 steady with din[0] toggling → gnt=01 one cycle later. It releases after 4 cycles (MAX_HOLD=4), is re-granted back-to-back, and out tracks din[0] throughout.
- req=8'hFF held for 40 cycles → grants rotate 0,1,2,…,7,0 with exactly 4 cycles each. busy stays 1 and there are no idle gaps.
- Grantee 3 drops req after 2 cycles while req[6]=1 → gnt goes 08→40 at the next edge and sel=6.
- Wrap test: last=7 and req=8'b1000_0001 → 0 is granted before 7. After 0's release, 7 is granted.
- rst=1 mid-grant (sel=5, counter=2) → next edge gnt=0, busy=0, out=0. After rst is deasserted with req=8'b0010_0001, requester 0 wins.
- All req drop during a grant → the next edge goes to IDLE with gnt=0 and busy=0. out=0 regardless of din.

Source files
------------

// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants and state type for the 8-way round-robin mux scheduler.
package mux8_rr_sched_pkg;
  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux8_rr_sched_pick.sv
// Rotating-priority scan: first requester after 'last', wrapping 7->0, ending at 'last' itself.
module rr_pick8
  import mux8_rr_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);
  logic [SEL_W-1:0] idx;

  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    // Offset NREQ truncates to 0, so the final probe is 'last' itself.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = last + SEL_W'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end
endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux; grants capped at MAX_HOLD cycles.
module mux8_rr_sched
  import mux8_rr_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       out
);
  state_t             state, state_n;
  logic [SEL_W-1:0]   sel_n, last, last_n, pick_last, win;
  logic [NREQ-1:0]    gnt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               any, rel;

  // On release the scan must start after the outgoing grantee, before 'last' is updated.
  assign pick_last = (state == ST_GRANT) ? sel : last;
  assign rel       = (state == ST_GRANT) &&
                     (!req[sel] || (cnt == CNT_W'(MAX_HOLD - 1)));

  rr_pick8 u_pick (
    .req  (req),
    .last (pick_last),
    .any  (any),
    .win  (win)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel;
    gnt_n   = gnt;
    cnt_n   = cnt;
    last_n  = last;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_n = ST_GRANT;
          sel_n   = win;
          gnt_n   = NREQ'(1) << win;
          cnt_n   = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          last_n = sel;
          if (any) begin
            sel_n = win;
            gnt_n = NREQ'(1) << win;
            cnt_n = '0;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      gnt   <= '0;
      cnt   <= '0;
      last  <= SEL_W'(NREQ - 1);
    end else begin
      state <= state_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end

  assign busy = (state == ST_GRANT);
  assign out  = busy ? din[sel] : 1'b0;
endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: directed scenarios plus random traffic vs a grantee-level model.
module tb_mux8_rr_sched;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, din, gnt;
  logic [2:0] sel;
  logic       busy, out;

  always #5 clk = ~clk;

  mux8_rr_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .busy(busy), .out(out)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       out;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: who holds the resource (-1 = nobody), how long, and who was served last.
  int m_owner = -1;
  int m_sel   = 0;
  int m_last  = 7;
  int m_held  = 0;

  function automatic int next_winner(input int lst, input logic [7:0] rq);
    for (int k = 1; k <= 8; k++)
      if (rq[(lst + k) % 8]) return (lst + k) % 8;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] rq);
    int w;
    if (r) begin
      m_owner = -1; m_sel = 0; m_last = 7; m_held = 0;
    end else if (m_owner < 0) begin
      w = next_winner(m_last, rq);
      if (w >= 0) begin m_owner = w; m_sel = w; m_held = 1; end
    end else if (!rq[m_owner] || m_held == MAX_HOLD) begin
      m_last = m_owner;
      w = next_winner(m_last, rq);
      if (w >= 0) begin m_owner = w; m_sel = w; m_held = 1; end
      else m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; din = d;
    model_step(r, rq);
    e.busy = (m_owner >= 0);
    e.gnt  = e.busy ? (8'd1 << m_owner) : 8'd0;
    e.sel  = 3'(m_sel);
    e.out  = e.busy ? d[m_sel] : 1'b0;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt",  gnt,        e.gnt);
        chk("sel",  8'(sel),    8'(e.sel));
        chk("busy", 8'(busy),   8'(e.busy));
        chk("out",  8'(out),    8'(e.out));
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; req = '0; din = '0;
    cyc(1, 8'h00, 8'h00);
    cyc(1, 8'h00, 8'hFF);
    // Single requester: expiry after MAX_HOLD, immediate re-grant, out follows din[0].
    for (int i = 0; i < 14; i++) cyc(0, 8'h01, 8'(i & 1));
    // All requesting: strict rotation, 4 cycles each.
    cyc(1, 8'h00, 8'h00);
    for (int i = 0; i < 40; i++) cyc(0, 8'hFF, 8'($urandom));
    // Grantee 3 drops after 2 cycles while 6 waits.
    cyc(1, 8'h00, 8'h00);
    cyc(0, 8'h08, 8'hFF);
    cyc(0, 8'h48, 8'hFF);
    cyc(0, 8'h48, 8'hF7);
    cyc(0, 8'h40, 8'h40);
    cyc(0, 8'h40, 8'h00);
    // Wrap: after reset last=7, so 0 precedes 7.
    cyc(1, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) cyc(0, 8'h81, 8'h81);
    // Reset mid-grant of requester 5, then 0 wins over 5.
    cyc(1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 8'h20, 8'hFF);
    cyc(1, 8'h21, 8'hFF);
    for (int i = 0; i < 3; i++) cyc(0, 8'h21, 8'hFF);
    // Everyone drops mid-grant: idle, out low regardless of din.
    cyc(0, 8'h0F, 8'hFF);
    cyc(0, 8'h00, 8'hFF);
    cyc(0, 8'h00, 8'hFF);
    // Random traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] rq;
      case ($urandom_range(0, 3))
        0: rq = 8'($urandom);
        1: rq = 8'($urandom) & 8'($urandom);
        2: rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
        default: rq = (m_owner >= 0 && $urandom_range(0, 1) == 1) ? 8'($urandom) | (8'd1 << m_owner) : 8'h00;
      endcase
      cyc(($urandom_range(0, 99) == 0), rq, 8'($urandom));
    end
    t = 0;
    while (q.size() > 0 && t < 10) begin
      @(posedge clk);
      t++;
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
